dm_access: RTL and testbench

Data-memory access unit for the pipelined MIPS core; it is the consumer of extended/narrowed operand data at the memory end of the datapath. It takes word-wide store data from the M stage and narrows it onto byte lanes (sb/sh/sw) into an internal word-organised data memory. On loads (lb/lbu/lh/lhu/lw) it extracts the addressed lane and sign- or zero-extends it into a registered W-stage result. Misaligned, out-of-range and conflicting requests are trapped and reported.

---
 rtl/dm_access.sv | 143 ++++++++++++++
 tb/tb_dm_access.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dm_access.sv
// Data-memory access unit: narrows stores onto byte lanes of a word memory and
// extends loaded lanes into a registered W-stage result, trapping bad requests.
module dm_access #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  input  logic [1:0]  store_op,
  input  logic [2:0]  load_op,
  output logic [31:0] rdata_W,
  output logic        rvalid_W,
  output logic        err_W,
  output logic [3:0]  be_M
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] idx_s;
  logic [1:0]            lane_s;
  logic                  range_err_s, conflict_s, mis_st_s, mis_ld_s;
  logic                  has_op_s, req_err_s, st_ok_s, ld_ok_s;
  logic [3:0]            be_raw_s;
  logic [31:0]           wlane_s, word_s, shifted_s, ext_s;

  // Request decode: address split, legality checks and store lane replication
  always_comb begin
    idx_s       = addr_M[ADDR_WIDTH+1:2];
    lane_s      = addr_M[1:0];
    range_err_s = |addr_M[31:ADDR_WIDTH+2];
    conflict_s  = ((store_op != 2'b00) && (load_op != 3'b000)) || (load_op[2:1] == 2'b11);

    case (store_op)
      2'b10:   mis_st_s = addr_M[0];
      2'b11:   mis_st_s = |addr_M[1:0];
      default: mis_st_s = 1'b0;
    endcase

    case (load_op)
      3'b011, 3'b100: mis_ld_s = addr_M[0];
      3'b101:         mis_ld_s = |addr_M[1:0];
      default:        mis_ld_s = 1'b0;
    endcase

    has_op_s  = (store_op != 2'b00) || (load_op != 3'b000);
    req_err_s = has_op_s && (range_err_s || conflict_s || mis_st_s || mis_ld_s);
    st_ok_s   = (store_op != 2'b00) && !req_err_s;
    ld_ok_s   = (load_op != 3'b000) && !req_err_s;

    case (store_op)
      2'b01:   be_raw_s = 4'b0001 << lane_s;
      2'b10:   be_raw_s = addr_M[1] ? 4'b1100 : 4'b0011;
      2'b11:   be_raw_s = 4'b1111;
      default: be_raw_s = 4'b0000;
    endcase

    if (st_ok_s) begin
      be_M = be_raw_s;
    end else begin
      be_M = 4'b0000;
    end

    case (store_op)
      2'b01:   wlane_s = {4{wdata_M[7:0]}};
      2'b10:   wlane_s = {2{wdata_M[15:0]}};
      default: wlane_s = wdata_M;
    endcase
  end

  // Load path: pick the addressed lane (half loads are aligned, so the same
  // byte shift lands on 0 or 16) and extend it to a full word
  always_comb begin
    word_s    = mem_q[idx_s];
    shifted_s = word_s >> {lane_s, 3'b000};
    case (load_op)
      3'b001:  ext_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b010:  ext_s = {24'h000000, shifted_s[7:0]};
      3'b011:  ext_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b100:  ext_s = {16'h0000, shifted_s[15:0]};
      default: ext_s = word_s;
    endcase
  end

  // Next-state for the W-stage result registers
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    err_d    = err_q;
    if (en) begin
      rvalid_d = ld_ok_s;
      err_d    = req_err_s;
      if (ld_ok_s) begin
        rdata_d = ext_s;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      err_d    = err_q;
    end
  end

  // W-stage result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q  <= 32'h0000_0000;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Word memory: cleared on reset, byte-lane writes on legal advancing stores
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (en && st_ok_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_M[b]) begin
          mem_q[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
        end
      end
    end
  end

  assign rdata_W  = rdata_q;
  assign rvalid_W = rvalid_q;
  assign err_W    = err_q;

endmodule

// File: tb/tb_dm_access.sv
// Directed-vector bench for dm_access: stimulus pushes expected W-stage
// responses into a queue that a separate monitor pops and compares.
module tb_dm_access;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] addr_M;
  logic [31:0] wdata_M;
  logic [1:0]  store_op;
  logic [2:0]  load_op;
  logic [31:0] rdata_W;
  logic        rvalid_W;
  logic        err_W;
  logic [3:0]  be_M;

  localparam logic [1:0] SNONE = 2'b00, SB = 2'b01, SH = 2'b10, SW = 2'b11;
  localparam logic [2:0] LNONE = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011,
                         LHU = 3'b100, LW = 3'b101, LBAD = 3'b110;
  localparam int K_NONE = 0, K_LOAD = 1, K_ERR = 2;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mx;
  int          checks = 0;
  int          passes = 0;
  logic        pv, pe;
  logic [31:0] pd;

  dm_access #(.ADDR_WIDTH(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .addr_M   (addr_M),
    .wdata_M  (wdata_M),
    .store_op (store_op),
    .load_op  (load_op),
    .rdata_W  (rdata_W),
    .rvalid_W (rvalid_W),
    .err_W    (err_W),
    .be_M     (be_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end else begin
      passes++;
    end
  endtask

  // One cycle: drive at negedge, check be_M combinationally, queue the W result
  task automatic step(input logic rst, input logic e, input logic [1:0] st,
                      input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd,
                      input int kind, input logic [31:0] ld_val,
                      input logic [3:0] xbe, input string nm);
    exp_t x;
    @(negedge clk);
    reset    = rst;
    en       = e;
    store_op = st;
    load_op  = ld;
    addr_M   = a;
    wdata_M  = wd;
    if (!rst) begin
      pv = 1'b0; pe = 1'b0; pd = 32'h0;
    end else if (e) begin
      case (kind)
        K_LOAD:  begin pv = 1'b1; pe = 1'b0; pd = ld_val; end
        K_ERR:   begin pv = 1'b0; pe = 1'b1; end
        default: begin pv = 1'b0; pe = 1'b0; end
      endcase
    end
    x.v = pv; x.e = pe; x.d = pd; x.nm = nm;
    exp_q.push_back(x);
    #1;
    chk({nm, ".be"}, {28'h0, be_M}, {28'h0, xbe});
  endtask

  // Monitor: the W outputs become visible just after each rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      chk({mx.nm, ".rvalid"}, {31'h0, rvalid_W}, {31'h0, mx.v});
      chk({mx.nm, ".err"},    {31'h0, err_W},    {31'h0, mx.e});
      chk({mx.nm, ".rdata"},  rdata_W,           mx.d);
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; addr_M = 32'h0; wdata_M = 32'h0;
    store_op = SNONE; load_op = LNONE;
    pv = 1'b0; pe = 1'b0; pd = 32'h0;

    step(1'b0, 1'b1, SNONE, LNONE, 32'h0, 32'h0, K_NONE, 32'h0, 4'b0000, "rst0");
    step(1'b0, 1'b1, SNONE, LNONE, 32'h0, 32'h0, K_NONE, 32'h0, 4'b0000, "rst1");
    step(1'b1, 1'b1, SNONE, LW,    32'h0, 32'h0, K_LOAD, 32'h0, 4'b0000, "lw0");

    // Lane merging
    step(1'b1, 1'b1, SW, LNONE, 32'h4, 32'h12345678, K_NONE, 32'h0, 4'b1111, "sw4");
    step(1'b1, 1'b1, SB, LNONE, 32'h5, 32'h000000AB, K_NONE, 32'h0, 4'b0010, "sb5");
    step(1'b1, 1'b1, SH, LNONE, 32'h6, 32'h0000CDEF, K_NONE, 32'h0, 4'b1100, "sh6");
    step(1'b1, 1'b1, SNONE, LW, 32'h4, 32'h0, K_LOAD, 32'hCDEFAB78, 4'b0000, "lw4");
    step(1'b1, 1'b1, SNONE, LNONE, 32'h0, 32'h0, K_NONE, 32'h0, 4'b0000, "idle");

    // Extension, including store-then-load in back-to-back cycles
    step(1'b1, 1'b1, SW, LNONE, 32'h8, 32'h80FF7F01, K_NONE, 32'h0, 4'b1111, "sw8");
    step(1'b1, 1'b1, SNONE, LB,  32'hB, 32'h0, K_LOAD, 32'hFFFFFF80, 4'b0000, "lbB");
    step(1'b1, 1'b1, SNONE, LBU, 32'hB, 32'h0, K_LOAD, 32'h00000080, 4'b0000, "lbuB");
    step(1'b1, 1'b1, SNONE, LH,  32'hA, 32'h0, K_LOAD, 32'hFFFF80FF, 4'b0000, "lhA");
    step(1'b1, 1'b1, SNONE, LHU, 32'h8, 32'h0, K_LOAD, 32'h00007F01, 4'b0000, "lhu8");
    step(1'b1, 1'b1, SNONE, LB,  32'h9, 32'h0, K_LOAD, 32'h0000007F, 4'b0000, "lb9");
    step(1'b1, 1'b1, SNONE, LH,  32'h8, 32'h0, K_LOAD, 32'h00007F01, 4'b0000, "lh8");
    step(1'b1, 1'b1, SNONE, LBU, 32'h9, 32'h0, K_LOAD, 32'h0000007F, 4'b0000, "lbu9");

    // Errors: misaligned, out-of-range, conflicting, illegal load
    step(1'b1, 1'b1, SH, LNONE, 32'h3, 32'h0000FFFF, K_ERR, 32'h0, 4'b0000, "sh3");
    step(1'b1, 1'b1, SNONE, LW, 32'h0, 32'h0, K_LOAD, 32'h0, 4'b0000, "lw0b");
    step(1'b1, 1'b1, SNONE, LW, 32'h2, 32'h0, K_ERR, 32'h0, 4'b0000, "lw2");
    step(1'b1, 1'b1, SW, LNONE, 32'h1000, 32'hFFFFFFFF, K_ERR, 32'h0, 4'b0000, "sw1000");
    step(1'b1, 1'b1, SNONE, LW, 32'h0, 32'h0, K_LOAD, 32'h0, 4'b0000, "lw0c");
    step(1'b1, 1'b1, SW, LW, 32'h4, 32'hFFFFFFFF, K_ERR, 32'h0, 4'b0000, "swlw");
    step(1'b1, 1'b1, SNONE, LW, 32'h4, 32'h0, K_LOAD, 32'hCDEFAB78, 4'b0000, "lw4b");
    step(1'b1, 1'b1, SNONE, LBAD, 32'h4, 32'h0, K_ERR, 32'h0, 4'b0000, "ldbad");
    step(1'b1, 1'b1, SNONE, LBU, 32'h1004, 32'h0, K_ERR, 32'h0, 4'b0000, "lbuoor");
    step(1'b1, 1'b1, SNONE, LNONE, 32'h0, 32'h0, K_NONE, 32'h0, 4'b0000, "idle2");

    // Stall: outputs and memory hold; lw completes on the first en=1 edge
    step(1'b1, 1'b1, SNONE, LHU, 32'h8, 32'h0, K_LOAD, 32'h00007F01, 4'b0000, "lhu8b");
    step(1'b1, 1'b0, SW, LNONE, 32'h8, 32'h11111111, K_NONE, 32'h0, 4'b1111, "stall0");
    step(1'b1, 1'b0, SW, LNONE, 32'h8, 32'h11111111, K_NONE, 32'h0, 4'b1111, "stall1");
    step(1'b1, 1'b0, SNONE, LW, 32'h8, 32'h0, K_NONE, 32'h0, 4'b0000, "stall2");
    step(1'b1, 1'b1, SNONE, LW, 32'h8, 32'h0, K_LOAD, 32'h80FF7F01, 4'b0000, "lw8");

    // Reset mid-stream clears memory and discards the in-flight store
    step(1'b1, 1'b1, SW, LNONE, 32'h10, 32'hCAFEF00D, K_NONE, 32'h0, 4'b1111, "sw10");
    step(1'b1, 1'b1, SNONE, LW, 32'h10, 32'h0, K_LOAD, 32'hCAFEF00D, 4'b0000, "lw10");
    step(1'b0, 1'b1, SW, LNONE, 32'h10, 32'hDEADBEEF, K_NONE, 32'h0, 4'b1111, "rstsw");
    step(1'b1, 1'b1, SNONE, LW, 32'h10, 32'h0, K_LOAD, 32'h0, 4'b0000, "lw10r");
    step(1'b1, 1'b1, SNONE, LW, 32'h8, 32'h0, K_LOAD, 32'h0, 4'b0000, "lw8r");
    step(1'b1, 1'b1, SNONE, LNONE, 32'h0, 32'h0, K_NONE, 32'h0, 4'b0000, "idle3");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
